// File: rtl/game_timer.sv
// Countdown game clock: 0..99 s budget with pause, restart and bonus pickups,
// BCD digit outputs and a game-over pulse. Optional warning blink: GAME_TIMER_WARN_EN.
module game_timer #(
  parameter int START_SEC = 60,
  parameter int BONUS_SEC = 5,
  parameter int WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       duty50,
  input  logic       start_game,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       time_up,
  output logic       game_over,
  output logic       warn
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic [6:0] START7     = 7'(START_SEC);
  localparam logic [7:0] BONUS8     = 8'(BONUS_SEC);
  localparam logic [7:0] MAX8       = 8'd99;
  localparam logic [3:0] START_TENS = 4'(START_SEC / 10);
  localparam logic [3:0] START_ONES = 4'(START_SEC % 10);

  state_t     r_state;
  logic [6:0] r_remain;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_running;
  logic       r_time_up;
  logic       r_game_over;

  state_t     w_next_state;
  logic [6:0] w_next_remain;
  logic       w_next_time_up;
  logic [3:0] w_next_tens;
  logic [3:0] w_next_ones;
  logic [7:0] w_bonus_add;

  function automatic logic [6:0] sat99(input logic [7:0] v);
    return (v > MAX8) ? 7'd99 : v[6:0];
  endfunction

  assign w_bonus_add = bonus ? BONUS8 : 8'd0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_next_state   = r_state;
    w_next_remain  = r_remain;
    w_next_time_up = 1'b0;

    if (start_game) begin
      w_next_state  = S_RUN;
      w_next_remain = START7;
    end else begin
      unique case (r_state)
        S_IDLE: w_next_remain = START7;
        S_RUN: begin
          if (pause) begin
            w_next_state  = S_PAUSED;
            w_next_remain = sat99({1'b0, r_remain} + w_bonus_add);
          end else begin
            // remain is never 0 in RUN, so the 8-bit decrement cannot wrap
            if (one_sec) w_next_remain = sat99({1'b0, r_remain} - 8'd1 + w_bonus_add);
            else         w_next_remain = sat99({1'b0, r_remain} + w_bonus_add);
            if (w_next_remain == 7'd0) begin
              w_next_state   = S_OVER;
              w_next_time_up = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          w_next_remain = sat99({1'b0, r_remain} + w_bonus_add);
          if (!pause) w_next_state = S_RUN;
        end
        S_OVER: w_next_remain = 7'd0;
        default: begin
          w_next_state  = S_IDLE;
          w_next_remain = START7;
        end
      endcase
    end

    w_next_tens = 4'(w_next_remain / 7'd10);
    w_next_ones = 4'(w_next_remain % 7'd10);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_remain    <= START7;
      r_tens      <= START_TENS;
      r_ones      <= START_ONES;
      r_running   <= 1'b0;
      r_time_up   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      r_state     <= w_next_state;
      r_remain    <= w_next_remain;
      r_tens      <= w_next_tens;
      r_ones      <= w_next_ones;
      r_running   <= (w_next_state == S_RUN);
      r_time_up   <= w_next_time_up;
      r_game_over <= (w_next_state == S_OVER);
    end
  end

`ifdef GAME_TIMER_WARN_EN
  logic r_warn;

  // Blink tracks the current registered budget, so it lags remain by one clock
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= ((r_state == S_RUN) || (r_state == S_PAUSED)) &&
                (r_remain <= 7'(WARN_SEC)) && (r_remain != 7'd0) && duty50;
    end
  end

  assign warn = r_warn;
`else
  logic w_unused_duty50;

  assign w_unused_duty50 = duty50;
  assign warn            = 1'b0;
`endif

  assign tens      = r_tens;
  assign ones      = r_ones;
  assign running   = r_running;
  assign time_up   = r_time_up;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: a rule-level model compared every cycle,
// plus hand-computed literal checkpoints along the directed scenarios.
module tb_game_timer;

  localparam int START_SEC = 60;
  localparam int BONUS_SEC = 5;
  localparam int WARN_SEC  = 10;

  logic       clk = 1'b0;
  logic       resetN;
  logic       one_sec, duty50, start_game, pause, bonus;
  logic [3:0] tens, ones;
  logic       running, time_up, game_over, warn;

  game_timer #(
    .START_SEC(START_SEC),
    .BONUS_SEC(BONUS_SEC),
    .WARN_SEC (WARN_SEC)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .one_sec   (one_sec),
    .duty50    (duty50),
    .start_game(start_game),
    .pause     (pause),
    .bonus     (bonus),
    .tens      (tens),
    .ones      (ones),
    .running   (running),
    .time_up   (time_up),
    .game_over (game_over),
    .warn      (warn)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_OVER} mode_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    m_rem;
  mode_t m_mode;
  bit    m_time_up;
  bit    m_warn;
  bit    m_valid = 1'b0;
  bit    tb_duty = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic model_reset();
    m_rem     = START_SEC;
    m_mode    = M_IDLE;
    m_time_up = 1'b0;
    m_warn    = 1'b0;
  endtask

  // One clock edge of the game rules, given the inputs sampled on that edge
  task automatic model_edge(input bit t, input bit b, input bit s, input bit p, input bit d);
    int    prev_rem;
    mode_t prev_mode;
    prev_rem  = m_rem;
    prev_mode = m_mode;
    m_time_up = 1'b0;
    if (s) begin
      m_rem  = START_SEC;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (p) begin
        m_rem  = sat(m_rem + (b ? BONUS_SEC : 0));
        m_mode = M_PAUSED;
      end else begin
        m_rem = sat(m_rem - (t ? 1 : 0) + (b ? BONUS_SEC : 0));
        if (m_rem == 0) begin
          m_mode    = M_OVER;
          m_time_up = 1'b1;
        end
      end
    end else if (m_mode == M_PAUSED) begin
      m_rem = sat(m_rem + (b ? BONUS_SEC : 0));
      if (!p) m_mode = M_RUN;
    end
`ifdef GAME_TIMER_WARN_EN
    m_warn = ((prev_mode == M_RUN) || (prev_mode == M_PAUSED)) &&
             (prev_rem <= WARN_SEC) && (prev_rem != 0) && d;
`else
    m_warn = 1'b0;
    if (prev_mode == M_OVER && prev_rem < 0 && d) m_warn = 1'b0;
`endif
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("tens",      int'(tens),      m_rem / 10);
      check("ones",      int'(ones),      m_rem % 10);
      check("running",   int'(running),   int'(m_mode == M_RUN));
      check("game_over", int'(game_over), int'(m_mode == M_OVER));
      check("time_up",   int'(time_up),   int'(m_time_up));
      check("warn",      int'(warn),      int'(m_warn));
    end
  end

  task automatic step(input bit t, input bit b, input bit s, input bit p);
    one_sec    = t;
    bonus      = b;
    start_game = s;
    pause      = p;
    duty50     = tb_duty;
    @(posedge clk);
    if (resetN) model_edge(t, b, s, p, tb_duty);
    @(negedge clk);
    #1;
    tb_duty = ~tb_duty;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic lit_digits(input string name, input int t, input int o);
    check({name, "_tens"}, int'(tens), t);
    check({name, "_ones"}, int'(ones), o);
  endtask

  initial begin
    resetN = 1'b1; one_sec = 1'b0; duty50 = 1'b0;
    start_game = 1'b0; pause = 1'b0; bonus = 1'b0;
    #2;
    model_reset();
    resetN  = 1'b0;
    m_valid = 1'b1;
    #1;
    lit_digits("reset", 6, 0);
    check("reset_running", int'(running), 0);
    check("reset_game_over", int'(game_over), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;

    // No start: 200 ticks leave the budget untouched
    tick_n(200);
    lit_digits("idle200", 6, 0);
    check("idle200_running", int'(running), 0);

    // Full countdown from 60
    step(1'b0, 1'b0, 1'b1, 1'b0);
    lit_digits("start", 6, 0);
    check("start_running", int'(running), 1);
    tick_n(59);
    lit_digits("at01", 0, 1);
    check("at01_game_over", int'(game_over), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit_digits("expire", 0, 0);
    check("expire_time_up", int'(time_up), 1);
    check("expire_game_over", int'(game_over), 1);
    check("expire_running", int'(running), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("time_up_one_cycle", int'(time_up), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit_digits("over_tick_bonus", 0, 0);
    check("over_stays", int'(game_over), 1);

    // Pause at 03
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick_n(57);
    lit_digits("at03", 0, 3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    lit_digits("paused", 0, 3);
    check("paused_running", int'(running), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_running", int'(running), 1);
    tick_n(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_expire_time_up", int'(time_up), 1);

    // Bonus accumulation and saturation
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit_digits("two_bonus", 7, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    lit_digits("bonus_sat", 9, 9);
    tick_n(2);
    lit_digits("at97", 9, 7);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit_digits("97_bonus", 9, 9);
    tick_n(98);
    lit_digits("at01b", 0, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit_digits("tick_bonus", 0, 5);
    check("tick_bonus_time_up", int'(time_up), 0);
    check("tick_bonus_running", int'(running), 1);

    // Restart priority over a same-cycle tick, then restart out of OVER
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tick_n(50);
    lit_digits("at10", 1, 0);
    tick_n(5);
`ifndef GAME_TIMER_WARN_EN
    check("warn_disabled", int'(warn), 0);
`endif
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lit_digits("start_tick", 6, 0);
    check("start_tick_running", int'(running), 1);
    tick_n(60);
    check("over_again", int'(game_over), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    lit_digits("over_restart", 6, 0);
    check("over_restart_running", int'(running), 1);

    // Asynchronous reset mid-game, asserted between clock edges
    tick_n(5);
    lit_digits("at55", 5, 5);
    #2;
    model_reset();
    resetN = 1'b0;
    #1;
    lit_digits("async_reset", 6, 0);
    check("async_reset_running", int'(running), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    tick_n(2);
    lit_digits("after_reset", 6, 0);

    m_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Countdown game clock driven by the one-second tick from the slow-clock counter. It holds a 0–99 second budget, decrements once per tick while the game runs, and supports pause, restart and bonus-time pickups. It drives two BCD digits to the seven-segment decoders and raises a game-over indication to the game controller.

## Interface
- `START_SEC`, default 60: value loaded on reset and on every start; legal range 1..99.
- `BONUS_SEC`, default 5: seconds added per `bonus` pulse; legal range 0..99.
- `WARN_SEC`, default 10: warning threshold; legal range 0..`START_SEC`-1.

- `clk` in 1: system clock, 50 MHz.
- `resetN` in 1: asynchronous, active-low reset.
- `one_sec` in 1: one-cycle tick, one per second or 1/16 s in turbo.
- `duty50` in 1: 0.5 Hz square wave, used only as the warning blink source.
- `start_game` in 1: one-cycle pulse that loads `START_SEC` and runs.
- `pause` in 1: level; while high, ticks are ignored.
- `bonus` in 1: one-cycle pulse that adds `BONUS_SEC`.
- `tens` out 4: BCD tens digit of the remaining seconds.
- `ones` out 4: BCD ones digit of the remaining seconds.
- `running` out 1: high in RUN.
- `time_up` out 1: one-cycle pulse on expiry.
- `game_over` out 1: high in OVER.
- `warn` out 1: low-time blink.

## Operation
- Internal state: 7-bit binary `remain` (0..99) and a four-state FSM: IDLE, RUN, PAUSED, OVER.
- All outputs are registered. `tens`/`ones` are derived from `remain` and registered in the same cycle as `remain` changes.
- Reset values:
  - FSM = IDLE, `remain` = `START_SEC`.
  - `tens`/`ones` = digits of `START_SEC`.
  - `running`, `time_up`, `game_over`, `warn` = 0.
- `start_game` in any state sets `remain` = `START_SEC` and the FSM = RUN. It has top priority: a same-cycle `one_sec` or `bonus` is discarded.
- IDLE:
  - Holds `START_SEC`.
  - `one_sec` and `bonus` are ignored.
- RUN:
  - `pause`=1: go to PAUSED; a same-cycle tick is ignored.
  - `one_sec`=1: next `remain` = `remain`-1+(`bonus`?`BONUS_SEC`:0), saturated at 99.
  - `bonus` without a tick: `remain` += `BONUS_SEC`, saturated at 99.
  - If the next `remain` = 0: go to OVER and assert `time_up` for exactly one cycle, aligned with the edge on which `remain` becomes 0.
- PAUSED:
  - Ticks are ignored.
  - `bonus` still adds time (saturated).
  - `pause`=0: return to RUN on the next edge.
- OVER:
  - `remain` = 0, `game_over` = 1.
  - `one_sec`, `bonus` and `pause` are ignored.
  - Only `start_game` or reset leaves OVER.
- Arithmetic: add and subtract are done in 8 bits and then clamped to 99. Decrement below 0 cannot happen, because OVER is entered at 0.
- Reset asserted mid-game returns to reset values immediately (asynchronous).

## Timing
- Tick-to-display latency: 1 clock. The digits change on the edge that samples `one_sec`=1.
- Bonus-to-display latency: 1 clock.
- `time_up` is high for exactly 1 clock. `game_over` and `running` change on the same edge as `time_up`.
- `pause` is sampled every clock. Pause/resume takes effect on the next edge; the tick phase is not realigned.
- Multiple `bonus` pulses on consecutive cycles each add `BONUS_SEC`.

## Configuration
- `GAME_TIMER_WARN_EN` defined:
  - `warn` is registered from (FSM=RUN or PAUSED) && `remain` ≤ `WARN_SEC` && `remain` ≠ 0 && `duty50`.
  - Latency is 1 clock from `duty50`/`remain`.
- `GAME_TIMER_WARN_EN` undefined:
  - `warn` is constant 0.
  - `duty50` is unused.
  - No comparator logic is synthesized.

## Test plan
- Reset, then no `start_game` for 200 ticks: `tens`=6, `ones`=0, `running`=0 throughout.
- `start_game`, then 60 ticks: digits count 59..01 then 00. `time_up` pulses once on the 60th tick and `game_over`=1. A 61st tick and a `bonus` leave 00.
- RUN at 03 with `pause`=1 over 5 ticks: digits stay 03. Release `pause`, then 3 ticks: `time_up` fires.
- RUN at 97 with `bonus` (`BONUS_SEC`=5): 99. RUN at 01 with `one_sec` and `bonus` in the same cycle: 05, no `time_up`.
- RUN at 10 with `start_game` and `one_sec` in the same cycle: 60, and the tick is lost. In OVER, `start_game` gives 60 and `running`=1.
- With `GAME_TIMER_WARN_EN` defined and `duty50` toggling: `warn` is 0 at 11, follows `duty50` from 10 through 01, and is 0 at 00. With the macro undefined, `warn` stays 0 throughout.
